fa_bist: RTL and testbench
==========================

# fa_bist

Hardware built-in self-test for the 1-bit full adder `fa`: the synthesizable counterpart of the full-adder stimulus bench. On a start request it drives all eight `{a,b,c_in}` combinations into an attached `fa` and waits a programmable settle time after each one. It then compares `sum`/`carry` against the golden full-adder function and reports pass/fail with an error count. It sits beside the `fa` instance it exercises and is controlled by a simple start/busy/done handshake.

## Interface
- `SETTLE`, default 2: cycles waited after driving a vector before sampling the DUT outputs. Legal range is 0..15.
- `ERR_W`, default 4: width of the error counter.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request. Sampled only in IDLE or DONE.
- `fa_sum` in 1: sum output from the DUT.
- `fa_carry` in 1: carry output from the DUT.
- `fa_a`, `fa_b`, `fa_c_in` out 1 each: registered stimulus to the DUT.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high in DONE. Holds until the next accepted start.
- `pass` out 1: valid while `done`=1. Equals 1 iff `err_count`==0.
- `err_count` out ERR_W: number of mismatching vectors, saturating at 2^ERR_W−1.
- `fail_vec` out 3: `{a,b,c_in}` of the first failing vector. Present only with `FA_BIST_CAPTURE_EN`.

## Operation
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE. Reset state is IDLE.
- **IDLE / DONE, start=1:**
  - Clear `err_count`.
  - Set vector index `vec`=0 and drive `{fa_a,fa_b,fa_c_in}`=3'b000.
  - Next state is APPLY.
- **IDLE, start=0:** remain in IDLE.
- **DONE, start=0:** remain in DONE.
- **APPLY:** one cycle. Load the settle counter with SETTLE. Next state is WAIT if SETTLE>0, else CHECK.
- **WAIT:** decrement the counter each cycle. Go to CHECK when it reaches 0. WAIT lasts exactly SETTLE cycles.
- **CHECK:** one cycle.
  - Expected sum = a^b^c_in.
  - Expected carry = (a&b)|(a&c_in)|(b&c_in).
  - Any mismatch on either bit increments `err_count` by 1 per vector, never by 2, and saturates.
  - If `vec`==7, go to DONE.
  - Otherwise `vec`+1, drive the new vector on the same edge, and go to APPLY.
- Vector order is 0..7, interpreted as `{a,b,c_in}` with `a` as the MSB. `vec` never wraps. A 3-bit counter stops at 7.
- `start` while `busy`=1 is ignored; the run is not restarted.
- Stimulus outputs hold their last vector (3'b111) in DONE.

## Timing
- Reset values: `fa_a`=`fa_b`=`fa_c_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0.
- Reset asserted mid-run clears every output asynchronously and returns the FSM to IDLE. No partial result is retained.
- `busy` rises on the edge that accepts `start`. It falls on the same edge that `done` rises.
- Per-vector time is SETTLE+2 cycles. `done` rises 8·(SETTLE+2) cycles after the accepting edge: 32 cycles with the defaults, 16 with SETTLE=0.
- DUT outputs are sampled in CHECK, which is SETTLE+1 cycles after the vector was driven.
- Simultaneous `start` and DONE → restart: `done` falls and `busy` rises on the same edge.

## Configuration
- **`FA_BIST_CAPTURE_EN` defined:**
  - `fail_vec` port exists.
  - On the first mismatching CHECK of a run, `fail_vec` latches `vec`.
  - Later failures do not overwrite it.
  - It is cleared to 0 when `start` is accepted.
- **`FA_BIST_CAPTURE_EN` undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- Correct `fa` attached, SETTLE=2, pulse `start` → `done`=1 at cycle 32, `pass`=1, `err_count`=0, and stimulus sequence 000..111 seen once each.
- `fa` model with carry stuck-at-0 → `err_count`=4 (vectors 011, 101, 110, 111), `pass`=0. With the capture macro, `fail_vec`=3'b011.
- `fa` model with sum inverted and carry stuck-at-1 → `err_count`=8 (one increment per vector despite two-bit mismatches).
- SETTLE=0 → `done` at cycle 16. Hold `start` high during the run → no restart, `done` still at cycle 16. Then a `start` in DONE → new run, `err_count` cleared.
- Drop `rst_n` at cycle 10 of a run → all outputs 0 immediately, FSM in IDLE. Release it and pulse `start` → a full, clean run completes.
- ERR_W=2 with all vectors failing → `err_count` saturates at 3.

Source files
------------

// File: rtl/fa_bist_if.sv
// fa_bist_if: control handshake plus stimulus/response wires between the
// BIST engine and the full adder under test. Includes fail_vec only when
// FA_BIST_CAPTURE_EN is defined.
interface fa_bist_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c_in;
  logic             fa_sum;
  logic             fa_carry;
`ifdef FA_BIST_CAPTURE_EN
  logic [2:0]       fail_vec;

  modport master (output start, fa_sum, fa_carry,
                  input  busy, done, pass, err_count, fa_a, fa_b, fa_c_in, fail_vec);
  modport slave  (input  start, fa_sum, fa_carry,
                  output busy, done, pass, err_count, fa_a, fa_b, fa_c_in, fail_vec);
`else
  modport master (output start, fa_sum, fa_carry,
                  input  busy, done, pass, err_count, fa_a, fa_b, fa_c_in);
  modport slave  (input  start, fa_sum, fa_carry,
                  output busy, done, pass, err_count, fa_a, fa_b, fa_c_in);
`endif
endinterface

// File: rtl/fa_bist.sv
// fa_bist: walks all eight {a,b,c_in} vectors through an attached full adder,
// waits SETTLE cycles after each, checks sum/carry against the golden
// function and reports pass plus a saturating error count.
// Optional first-failure capture: define FA_BIST_CAPTURE_EN.
module fa_bist #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fa_bist_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [3:0]       SET_LD  = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [2:0]       vec;      // current vector; also the registered stimulus
  logic [3:0]       cnt;
  logic [ERR_W-1:0] err;
  logic             accept;
  logic             exp_sum, exp_carry, mismatch;

  assign accept    = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
  assign exp_sum   = vec[2] ^ vec[1] ^ vec[0];
  assign exp_carry = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch  = (bus.fa_sum != exp_sum) || (bus.fa_carry != exp_carry);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: APPLY and CHECK are single cycles, WAIT lasts SETTLE cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_APPLY;
      S_APPLY: state_nxt = (SETTLE > 0) ? S_WAIT : S_CHECK;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (vec == 3'd7) ? S_DONE : S_APPLY;
      S_DONE:  if (bus.start) state_nxt = S_APPLY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // vector index, settle counter and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= 3'd0;
      cnt <= 4'd0;
      err <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          vec <= 3'd0;
          err <= '0;
        end
        S_APPLY: cnt <= SET_LD;
        S_WAIT:  cnt <= cnt - 4'd1;
        S_CHECK: begin
          // one increment per vector even when both bits are wrong
          if (mismatch && (err != ERR_MAX)) err <= err + 1'b1;
          // index stops at 7 so the last vector is held through DONE
          if (vec != 3'd7) vec <= vec + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FA_BIST_CAPTURE_EN
  logic [2:0] fail_vec;

  // latch the first failing vector of a run; err==0 means no earlier failure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          fail_vec <= 3'd0;
    else if (accept)                                     fail_vec <= 3'd0;
    else if ((state == S_CHECK) && mismatch && (err == '0)) fail_vec <= vec;
  end

  assign bus.fail_vec = fail_vec;
`endif

  assign bus.fa_a      = vec[2];
  assign bus.fa_b      = vec[1];
  assign bus.fa_c_in   = vec[0];
  assign bus.busy      = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = (state == S_DONE) && (err == '0);
  assign bus.err_count = err;

endmodule

// File: tb/tb_fa_bist.sv
// tb_fa_bist: two engines (SETTLE=2/ERR_W=4 and SETTLE=0/ERR_W=2) each drive
// a bench-side adder model with per-vector fault masks. The model's response
// lags the stimulus by SETTLE+1 cycles, so only an on-time sample is correct.
module tb_fa_bist;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  fa_bist_if #(.ERR_W(4)) bus0 ();
  fa_bist_if #(.ERR_W(2)) bus1 ();

  fa_bist #(.SETTLE(2), .ERR_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  fa_bist #(.SETTLE(0), .ERR_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // fault masks: bit v flips the sum/carry answer for vector v
  logic [7:0] sm0 = 8'h00, cm0 = 8'h00, sm1 = 8'h00, cm1 = 8'h00;
  logic [2:0] dly0 [3];
  logic [2:0] dly1;
  logic [1:0] r0, r1;

  always @(posedge clk) begin
    dly0[0] <= {bus0.fa_a, bus0.fa_b, bus0.fa_c_in};
    dly0[1] <= dly0[0];
    dly0[2] <= dly0[1];
    dly1    <= {bus1.fa_a, bus1.fa_b, bus1.fa_c_in};
  end

  // {carry,sum} is just the arithmetic sum of the three input bits
  function automatic logic [1:0] fa_ref(input logic [2:0] v);
    int s;
    s = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return 2'(s);
  endfunction

  assign r0            = fa_ref(dly0[2]);
  assign r1            = fa_ref(dly1);
  assign bus0.fa_sum   = r0[0] ^ sm0[dly0[2]];
  assign bus0.fa_carry = r0[1] ^ cm0[dly0[2]];
  assign bus1.fa_sum   = r1[0] ^ sm1[dly1];
  assign bus1.fa_carry = r1[1] ^ cm1[dly1];

  function automatic int n_fail(input logic [7:0] sm, input logic [7:0] cm);
    int n = 0;
    for (int v = 0; v < 8; v++) if (sm[v] || cm[v]) n++;
    return n;
  endfunction

  function automatic int first_fail(input logic [7:0] sm, input logic [7:0] cm);
    for (int v = 0; v < 8; v++) if (sm[v] || cm[v]) return v;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // one run on u0 (SETTLE=2): done expected 32 edges after acceptance
  task automatic run0(input string tag, input logic [7:0] sm, input logic [7:0] cm,
                      input int exp_err, input int exp_pass, input int exp_fv);
    int n;
    bit busy_ok, seq_ok;
    logic [2:0] q[$];
    logic [2:0] v;
    sm0 = sm; cm0 = cm;
    @(negedge clk); bus0.start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".acc_busy"}, bus0.busy, 1);
    check({tag, ".acc_done"}, bus0.done, 0);
    check({tag, ".acc_err"}, bus0.err_count, 0);
    q.delete();
    q.push_back({bus0.fa_a, bus0.fa_b, bus0.fa_c_in});
    busy_ok = 1; n = 0;
    while (n < 100) begin
      @(negedge clk); bus0.start = 1'b0;
      @(posedge clk); #1; n++;
      if (bus0.done) break;
      if (!bus0.busy) busy_ok = 0;
      v = {bus0.fa_a, bus0.fa_b, bus0.fa_c_in};
      if (v != q[$]) q.push_back(v);
    end
    seq_ok = (q.size() == 8);
    for (int i = 0; i < q.size(); i++) if (int'(q[i]) != i) seq_ok = 0;
    check({tag, ".done_cyc"}, n, 32);
    check({tag, ".busy_fall"}, bus0.busy, 0);
    check({tag, ".busy_held"}, busy_ok, 1);
    check({tag, ".seq"}, seq_ok, 1);
    check({tag, ".err"}, bus0.err_count, exp_err);
    check({tag, ".pass"}, bus0.pass, exp_pass);
`ifdef FA_BIST_CAPTURE_EN
    check({tag, ".fail_vec"}, bus0.fail_vec, exp_fv);
`else
    if (exp_fv < 0) check({tag, ".fv_arg"}, exp_fv, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold"}, {bus0.done, bus0.fa_a, bus0.fa_b, bus0.fa_c_in}, 15);
  endtask

  // one run on u1 (SETTLE=0, ERR_W=2): done expected 16 edges after acceptance
  task automatic run1(input string tag, input logic [7:0] sm, input logic [7:0] cm,
                      input bit hold, input int exp_err, input int exp_pass, input int exp_fv);
    int n;
    sm1 = sm; cm1 = cm;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".acc_busy"}, bus1.busy, 1);
    check({tag, ".acc_done"}, bus1.done, 0);
    check({tag, ".acc_err"}, bus1.err_count, 0);
    n = 0;
    while (n < 100) begin
      @(negedge clk); if (!hold) bus1.start = 1'b0;
      @(posedge clk); #1; n++;
      if (bus1.done) break;
    end
    if (hold) begin
      @(negedge clk); bus1.start = 1'b0;
    end
    check({tag, ".done_cyc"}, n, 16);
    check({tag, ".err"}, bus1.err_count, exp_err);
    check({tag, ".pass"}, bus1.pass, exp_pass);
`ifdef FA_BIST_CAPTURE_EN
    check({tag, ".fail_vec"}, bus1.fail_vec, exp_fv);
`else
    if (exp_fv < 0) check({tag, ".fv_arg"}, exp_fv, 0);
`endif
  endtask

  typedef struct {
    string      name;
    logic [7:0] sm;
    logic [7:0] cm;
    int         exp_err;
    int         exp_pass;
    int         exp_fv;
  } vec_t;

  vec_t tbl [3];

  initial begin
    logic [7:0] sm, cm;
    int nf;
    tbl[0] = '{"good",     8'h00, 8'h00, 0, 1, 0};
    tbl[1] = '{"c_sa0",    8'h00, 8'hE8, 4, 0, 3};
    tbl[2] = '{"sinv_c1",  8'hFF, 8'h17, 8, 0, 0};

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", bus0.busy, 0);
    check("rst.done", bus0.done, 0);
    check("rst.pass", bus0.pass, 0);
    check("rst.err", bus0.err_count, 0);
    check("rst.stim", {bus0.fa_a, bus0.fa_b, bus0.fa_c_in}, 0);
`ifdef FA_BIST_CAPTURE_EN
    check("rst.fail_vec", bus0.fail_vec, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle.stay", {bus0.busy, bus0.done, bus1.busy, bus1.done}, 0);

    for (int i = 0; i < 3; i++)
      run0(tbl[i].name, tbl[i].sm, tbl[i].cm, tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_fv);

    for (int i = 0; i < 4; i++) begin
      sm = 8'($urandom) & 8'($urandom);
      cm = 8'($urandom) & 8'($urandom);
      nf = n_fail(sm, cm);
      run0($sformatf("rnd0_%0d", i), sm, cm, nf, (nf == 0) ? 1 : 0, first_fail(sm, cm));
    end

    // reset in the middle of a failing run
    sm0 = 8'hFF; cm0 = 8'h00;
    @(negedge clk); bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus0.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid.pre_err", bus0.err_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid.busy", bus0.busy, 0);
    check("mid.done", bus0.done, 0);
    check("mid.err", bus0.err_count, 0);
    check("mid.stim", {bus0.fa_a, bus0.fa_b, bus0.fa_c_in}, 0);
`ifdef FA_BIST_CAPTURE_EN
    check("mid.fail_vec", bus0.fail_vec, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    run0("after_rst", 8'h00, 8'h00, 0, 1, 0);

    // SETTLE=0 engine: saturation with start held, then restart from DONE
    run1("sat_hold", 8'hFF, 8'hFF, 1'b1, 3, 0, 0);
    run1("restart", 8'h00, 8'h00, 1'b0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      sm = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cm = 8'($urandom) & 8'($urandom) & 8'($urandom);
      nf = n_fail(sm, cm);
      run1($sformatf("rnd1_%0d", i), sm, cm, 1'b0, (nf > 3) ? 3 : nf,
           (nf == 0) ? 1 : 0, first_fail(sm, cm));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
